// File: rtl/vga_pkg.sv
// Shared video constants, the RGB444 pixel type and the rectangle-fill state enum.
// Also used by the VGA controller and the frame dump, so keep it free of block-specific logic.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int AW       = 19;
  localparam int DW       = 12;

  // Sized copies of the screen limits so comparisons against coordinates stay width-exact
  localparam logic [9:0]    H_LAST   = 10'(H_ACTIVE - 1);
  localparam logic [8:0]    V_LAST   = 9'(V_ACTIVE - 1);
  localparam logic [AW-1:0] H_STRIDE = AW'(H_ACTIVE);

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } pixel_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLIP = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } rect_state_t;

  function automatic logic [3:0] pix_r(input pixel_t p);
    return p.r;
  endfunction

  function automatic logic [3:0] pix_g(input pixel_t p);
    return p.g;
  endfunction

  function automatic logic [3:0] pix_b(input pixel_t p);
    return p.b;
  endfunction

  function automatic pixel_t pix_pack(input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
    pixel_t p;
    p.r = r;
    p.g = g;
    p.b = b;
    return p;
  endfunction

endpackage

// File: rtl/vram_rect_fill_if.sv
// Command handshake plus VRAM write-port bundle for the rectangle filler.
// slave = the filler itself, master = whoever issues commands and owns the RAM port.
interface vram_rect_fill_if;
  import vga_pkg::*;

  logic          cmd_valid;
  logic          cmd_ready;
  logic [9:0]    cmd_x0;
  logic [8:0]    cmd_y0;
  logic [9:0]    cmd_x1;
  logic [8:0]    cmd_y1;
  logic [DW-1:0] cmd_color;
  logic          wr_stall;
  logic          vram_we;
  logic [AW-1:0] vram_addr_w;
  logic [DW-1:0] vram_din;
  logic          busy;
  logic          done;

  modport slave (
    input  cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color, wr_stall,
    output cmd_ready, vram_we, vram_addr_w, vram_din, busy, done
  );

  modport master (
    output cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color, wr_stall,
    input  cmd_ready, vram_we, vram_addr_w, vram_din, busy, done
  );

endinterface

// File: rtl/rect_clip.sv
// Clamps a rectangle's far corner to the visible screen and flags rectangles that
// end up with no visible pixels. Purely combinational; the caller registers the result.
module rect_clip
  import vga_pkg::*;
(
  input  logic [9:0] i_x0,
  input  logic [8:0] i_y0,
  input  logic [9:0] i_x1,
  input  logic [8:0] i_y1,
  output logic [9:0] o_xe,
  output logic [8:0] o_ye,
  output logic       o_empty
);

  assign o_xe = (i_x1 > H_LAST) ? H_LAST : i_x1;
  assign o_ye = (i_y1 > V_LAST) ? V_LAST : i_y1;

  // A start corner past the screen edge or past the clamped end leaves nothing to draw
  assign o_empty = (i_x0 > o_xe) || (i_y0 > o_ye) || (i_x0 > H_LAST) || (i_y0 > V_LAST);

endmodule

// File: rtl/vram_rect_fill.sv
// Rectangle-fill engine: accepts one command, clips it, then streams one pixel write
// per non-stalled cycle in row-major order into the 640x480 RGB444 video RAM.
module vram_rect_fill
  import vga_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  vram_rect_fill_if.slave  bus
);

  rect_state_t   r_state;
  rect_state_t   w_next;

  logic [9:0]    r_x0;
  logic [8:0]    r_y0;
  logic [9:0]    r_x1;
  logic [8:0]    r_y1;
  pixel_t        r_color;

  logic [9:0]    r_xe;
  logic [8:0]    r_ye;
  logic [9:0]    r_col;
  logic [8:0]    r_row;
  logic [AW-1:0] r_row_base;

  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_din;

  logic [9:0]    w_xe;
  logic [8:0]    w_ye;
  logic          w_empty;
  logic          w_last;
  logic [AW-1:0] w_y0_ext;
  logic [AW-1:0] w_base;

  rect_clip u_clip (
    .i_x0    (r_x0),
    .i_y0    (r_y0),
    .i_x1    (r_x1),
    .i_y1    (r_y1),
    .o_xe    (w_xe),
    .o_ye    (w_ye),
    .o_empty (w_empty)
  );

  // y0*640 as (y0<<9)+(y0<<7); only needed once per command, rows then step by H_STRIDE
  assign w_y0_ext = {{(AW-9){1'b0}}, r_y0};
  assign w_base   = (w_y0_ext << 9) + (w_y0_ext << 7);
  assign w_last   = (r_col >= r_xe) && (r_row >= r_ye);

  // State register; reset abandons any command in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode; a stalled cycle never advances out of FILL
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.cmd_valid) w_next = CLIP;
      CLIP:    w_next = w_empty ? DONE : FILL;
      FILL:    if (!bus.wr_stall && w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Command latch, clip capture, scan counters and the registered write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x0       <= '0;
      r_y0       <= '0;
      r_x1       <= '0;
      r_y1       <= '0;
      r_color    <= '0;
      r_xe       <= '0;
      r_ye       <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_row_base <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_din      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.cmd_valid) begin
            r_x0    <= bus.cmd_x0;
            r_y0    <= bus.cmd_y0;
            r_x1    <= bus.cmd_x1;
            r_y1    <= bus.cmd_y1;
            r_color <= bus.cmd_color;
          end
        end
        CLIP: begin
          r_xe       <= w_xe;
          r_ye       <= w_ye;
          r_col      <= r_x0;
          r_row      <= r_y0;
          r_row_base <= w_base;
          if (!w_empty) begin
            r_we   <= 1'b1;
            r_addr <= w_base + AW'(r_x0);
            r_din  <= r_color;
          end
        end
        FILL: begin
          if (!bus.wr_stall) begin
            if (r_col < r_xe) begin
              r_col  <= r_col + 10'd1;
              r_addr <= r_addr + 19'd1;
            end else if (r_row < r_ye) begin
              r_col      <= r_x0;
              r_row      <= r_row + 9'd1;
              r_row_base <= r_row_base + H_STRIDE;
              r_addr     <= r_row_base + H_STRIDE + AW'(r_x0);
            end else begin
              r_we <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.cmd_ready   = (r_state == IDLE);
  assign bus.busy        = (r_state != IDLE);
  assign bus.done        = (r_state == DONE);
  assign bus.vram_we     = r_we;
  assign bus.vram_addr_w = r_addr;
  assign bus.vram_din    = r_din;

endmodule

// File: tb/tb_vram_rect_fill.sv
// Self-checking bench for vram_rect_fill: directed corner cases plus randomized rectangles
// with random stalls, all checked against a plain row-major pixel-list model.
module tb_vram_rect_fill;
  import vga_pkg::*;

  logic clk;
  logic rst;
  vram_rect_fill_if bus ();

  vram_rect_fill dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  int gotAddr[$];
  int gotData[$];
  int gotRel[$];
  int expAddr[$];
  int relCnt    = 0;
  int doneRel   = -1;
  int readyRel  = -1;
  int doneCount = 0;
  int weEver    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observe the write port mid-cycle; rel counts clock edges since the accept edge
  always @(negedge clk) begin
    relCnt = relCnt + 1;
    if (!rst) begin
      if (bus.vram_we) weEver = weEver + 1;
      if (bus.vram_we && !bus.wr_stall) begin
        gotAddr.push_back(int'(bus.vram_addr_w));
        gotData.push_back(int'(bus.vram_din));
        gotRel.push_back(relCnt);
      end
      if (bus.done) begin
        doneCount = doneCount + 1;
        if (doneRel < 0) doneRel = relCnt;
      end
      if (bus.cmd_ready && readyRel < 0) readyRel = relCnt;
    end
  end

  // Reference: every visible pixel of the clipped rectangle, row-major
  task automatic build_model(input int x0, input int y0, input int x1, input int y1);
    int xe;
    int ye;
    xe = (x1 > H_ACTIVE - 1) ? H_ACTIVE - 1 : x1;
    ye = (y1 > V_ACTIVE - 1) ? V_ACTIVE - 1 : y1;
    expAddr.delete();
    if (x0 <= xe && y0 <= ye && x0 < H_ACTIVE && y0 < V_ACTIVE)
      for (int y = y0; y <= ye; y++)
        for (int x = x0; x <= xe; x++)
          expAddr.push_back(y * H_ACTIVE + x);
  endtask

  // Present one command for exactly one accept edge and reset the observation state
  task automatic send_cmd(input int x0, input int y0, input int x1, input int y1, input int color);
    @(posedge clk);
    #1;
    bus.cmd_x0    = 10'(x0);
    bus.cmd_y0    = 9'(y0);
    bus.cmd_x1    = 10'(x1);
    bus.cmd_y1    = 9'(y1);
    bus.cmd_color = 12'(color);
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    gotAddr.delete();
    gotData.delete();
    gotRel.delete();
    relCnt    = 0;
    doneRel   = -1;
    readyRel  = -1;
    doneCount = 0;
    weEver    = 0;
  endtask

  // Run until cmd_ready returns; optionally jitter wr_stall and poke ignored commands while busy
  task automatic wait_idle(input int budget, input bit jitter, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk);
      #1;
      if (readyRel >= 0) begin
        ok = 1'b1;
        break;
      end
      if (jitter) begin
        bus.wr_stall = ($urandom_range(0, 2) == 0);
        if (bus.busy && !bus.done) begin
          bus.cmd_valid = $urandom_range(0, 1) == 1;
          bus.cmd_x0    = 10'($urandom_range(0, 1023));
          bus.cmd_y0    = 9'($urandom_range(0, 511));
          bus.cmd_x1    = 10'($urandom_range(0, 1023));
          bus.cmd_y1    = 9'($urandom_range(0, 511));
          bus.cmd_color = 12'($urandom);
        end else begin
          bus.cmd_valid = 1'b0;
        end
      end
    end
    bus.wr_stall  = 1'b0;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.wr_stall  = 1'b0;
    bus.cmd_x0    = '0;
    bus.cmd_y0    = '0;
    bus.cmd_x1    = '0;
    bus.cmd_y1    = '0;
    bus.cmd_color = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_cmd_ready got %0b exp 1", bus.cmd_ready); end
    checks++; if (bus.vram_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_we got %0b exp 0", bus.vram_we); end
    checks++; if (bus.vram_addr_w !== 19'd0) begin errors++; $display("[TB] FAIL reset_addr got %0d exp 0", bus.vram_addr_w); end
    checks++; if (bus.vram_din !== 12'd0) begin errors++; $display("[TB] FAIL reset_din got %0h exp 0", bus.vram_din); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %0b exp 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %0b exp 0", bus.done); end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_idle got ready=%0b busy=%0b exp ready=1 busy=0", bus.cmd_ready, bus.busy); end
  endtask

  task automatic test_single_pixel();
    bit ok;
    send_cmd(5, 3, 5, 3, 12'hF00);
    wait_idle(50, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL single_timeout got idle=0 exp idle=1"); end
    checks++; if (gotAddr.size() !== 1) begin errors++; $display("[TB] FAIL single_count got %0d exp 1", gotAddr.size()); end
    if (gotAddr.size() > 0) begin
      checks++; if (gotAddr[0] !== 1925) begin errors++; $display("[TB] FAIL single_addr got %0d exp 1925", gotAddr[0]); end
      checks++; if (gotData[0] !== 'hF00) begin errors++; $display("[TB] FAIL single_din got %0h exp f00", gotData[0]); end
      checks++; if (gotRel[0] !== 2) begin errors++; $display("[TB] FAIL single_latency got %0d exp 2", gotRel[0]); end
    end
    checks++; if (doneRel !== 3 || doneCount !== 1) begin errors++; $display("[TB] FAIL single_done got rel=%0d n=%0d exp rel=3 n=1", doneRel, doneCount); end
  endtask

  task automatic test_clip_edge();
    bit ok;
    build_model(638, 0, 640, 1);
    send_cmd(638, 0, 640, 1, 12'h0A5);
    wait_idle(50, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL clip_timeout got idle=0 exp idle=1"); end
    checks++; if (gotAddr.size() !== 4) begin errors++; $display("[TB] FAIL clip_count got %0d exp 4", gotAddr.size()); end
    for (int i = 0; i < expAddr.size() && i < gotAddr.size(); i++) begin
      checks++; if (gotAddr[i] !== expAddr[i]) begin errors++; $display("[TB] FAIL clip_addr[%0d] got %0d exp %0d", i, gotAddr[i], expAddr[i]); end
      checks++; if (gotData[i] !== 'h0A5) begin errors++; $display("[TB] FAIL clip_din[%0d] got %0h exp 0a5", i, gotData[i]); end
    end
  endtask

  task automatic test_corner();
    bit ok;
    send_cmd(639, 479, 1023, 511, 12'h123);
    wait_idle(50, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL corner_timeout got idle=0 exp idle=1"); end
    checks++; if (gotAddr.size() !== 1) begin errors++; $display("[TB] FAIL corner_count got %0d exp 1", gotAddr.size()); end
    if (gotAddr.size() > 0) begin
      checks++; if (gotAddr[0] !== 307199) begin errors++; $display("[TB] FAIL corner_addr got %0d exp 307199", gotAddr[0]); end
    end
  endtask

  task automatic test_empty();
    bit ok;
    int xs0[2] = '{10, 700};
    int xs1[2] = '{4, 705};
    for (int k = 0; k < 2; k++) begin
      send_cmd(xs0[k], 2, xs1[k], 3, 12'hFFF);
      wait_idle(50, 1'b0, ok);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL empty%0d_timeout got idle=0 exp idle=1", k); end
      checks++; if (weEver !== 0) begin errors++; $display("[TB] FAIL empty%0d_we got %0d cycles exp 0", k, weEver); end
      checks++; if (doneRel !== 2) begin errors++; $display("[TB] FAIL empty%0d_done got %0d exp 2", k, doneRel); end
      checks++; if (readyRel !== 3) begin errors++; $display("[TB] FAIL empty%0d_ready got %0d exp 3", k, readyRel); end
    end
  endtask

  task automatic test_stall();
    bit ok;
    build_model(100, 7, 103, 7);
    send_cmd(100, 7, 103, 7, 12'h5A5);
    @(posedge clk);
    @(posedge clk);
    #1 bus.wr_stall = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (bus.vram_we !== 1'b1 || int'(bus.vram_addr_w) !== expAddr[1] || bus.vram_din !== 12'h5A5) begin
        errors++;
        $display("[TB] FAIL stall_hold got we=%0b addr=%0d din=%0h exp we=1 addr=%0d din=5a5", bus.vram_we, bus.vram_addr_w, bus.vram_din, expAddr[1]);
      end
      @(posedge clk);
    end
    #1 bus.wr_stall = 1'b0;
    wait_idle(50, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL stall_timeout got idle=0 exp idle=1"); end
    checks++; if (gotAddr.size() !== 4) begin errors++; $display("[TB] FAIL stall_count got %0d exp 4", gotAddr.size()); end
    for (int i = 0; i < expAddr.size() && i < gotAddr.size(); i++) begin
      checks++; if (gotAddr[i] !== expAddr[i]) begin errors++; $display("[TB] FAIL stall_addr[%0d] got %0d exp %0d", i, gotAddr[i], expAddr[i]); end
    end
    checks++; if (doneRel !== 9) begin errors++; $display("[TB] FAIL stall_done got %0d exp 9", doneRel); end
  endtask

  task automatic test_reset_mid_fill();
    bit ok;
    bit hit;
    build_model(20, 30, 119, 129);
    send_cmd(20, 30, 119, 129, 12'h0F0);
    hit = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk);
      if (gotAddr.size() >= 50) begin
        hit = 1'b1;
        break;
      end
    end
    checks++; if (!hit) begin errors++; $display("[TB] FAIL midreset_reach50 got %0d writes exp 50", gotAddr.size()); end
    #1 rst = 1'b1;
    #1;
    checks++; if (bus.vram_we !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_stop got we=%0b busy=%0b exp 0 0", bus.vram_we, bus.busy); end
    checks++; if (gotAddr.size() !== 50) begin errors++; $display("[TB] FAIL midreset_writes got %0d exp 50", gotAddr.size()); end
    for (int i = 0; i < 50 && i < gotAddr.size(); i++) begin
      checks++; if (gotAddr[i] !== expAddr[i]) begin errors++; $display("[TB] FAIL midreset_addr[%0d] got %0d exp %0d", i, gotAddr[i], expAddr[i]); end
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.cmd_ready !== 1'b1 || bus.vram_we !== 1'b0) begin errors++; $display("[TB] FAIL midreset_release got ready=%0b we=%0b exp 1 0", bus.cmd_ready, bus.vram_we); end
    build_model(1, 1, 2, 2);
    send_cmd(1, 1, 2, 2, 12'h00F);
    wait_idle(50, 1'b0, ok);
    checks++; if (!ok || gotAddr.size() !== expAddr.size()) begin errors++; $display("[TB] FAIL midreset_next_count got %0d exp %0d", gotAddr.size(), expAddr.size()); end
    for (int i = 0; i < expAddr.size() && i < gotAddr.size(); i++) begin
      checks++; if (gotAddr[i] !== expAddr[i] || gotData[i] !== 'h00F) begin errors++; $display("[TB] FAIL midreset_next[%0d] got %0d/%0h exp %0d/00f", i, gotAddr[i], gotData[i], expAddr[i]); end
    end
  endtask

  task automatic test_random();
    bit ok;
    int x0, y0, x1, y1, color;
    for (int n = 0; n < 10; n++) begin
      x0    = (n % 3 == 0) ? $urandom_range(630, 700) : $urandom_range(0, 639);
      y0    = (n % 4 == 1) ? $urandom_range(474, 500) : $urandom_range(0, 479);
      x1    = x0 + $urandom_range(0, 12) - 2;
      y1    = y0 + $urandom_range(0, 5) - 1;
      if (x1 < 0) x1 = 0;
      if (y1 < 0) y1 = 0;
      if (y1 > 511) y1 = 511;
      color = $urandom_range(0, 4095);
      build_model(x0, y0, x1, y1);
      send_cmd(x0, y0, x1, y1, color);
      wait_idle(3000, 1'b1, ok);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL rand%0d_timeout got idle=0 exp idle=1", n); end
      checks++; if (gotAddr.size() !== expAddr.size()) begin errors++; $display("[TB] FAIL rand%0d_count got %0d exp %0d", n, gotAddr.size(), expAddr.size()); end
      for (int i = 0; i < expAddr.size() && i < gotAddr.size(); i++) begin
        checks++;
        if (gotAddr[i] !== expAddr[i] || gotData[i] !== color) begin
          errors++;
          $display("[TB] FAIL rand%0d_pix[%0d] got %0d/%0h exp %0d/%0h", n, i, gotAddr[i], gotData[i], expAddr[i], color);
        end
      end
      checks++; if (doneCount !== 1 || readyRel !== doneRel + 1) begin errors++; $display("[TB] FAIL rand%0d_done got n=%0d ready=%0d exp n=1 ready=%0d", n, doneCount, readyRel, doneRel + 1); end
    end
  endtask

  initial begin
    test_reset();
    test_single_pixel();
    test_clip_edge();
    test_corner();
    test_empty();
    test_stall();
    test_reset_mid_fill();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vram_rect_fill.md
Name: vram_rect_fill

Overview:
- Upstream producer for the 640x480, 12-bit RGB444 video RAM write port.
- Accepts rectangle-fill commands through a valid/ready handshake and clips each rectangle to the screen.
- Emits one pixel write per enabled cycle, producing the 19-bit write address and 12-bit pixel data.
- The VGA controller concurrently reads the other RAM port.

Parameters:
- H_ACTIVE, 640, visible columns
- V_ACTIVE, 480, visible rows
- AW, 19, write address width
- DW, 12, pixel width {r[3:0], g[3:0], b[3:0]}

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_x0  in  10  left column, inclusive
- cmd_y0  in  9  top row, inclusive
- cmd_x1  in  10  right column, inclusive
- cmd_y1  in  9  bottom row, inclusive
- cmd_color  in  12  fill colour
- wr_stall  in  1  RAM port busy; hold the current write
- vram_we  out  1  write enable
- vram_addr_w  out  19  write address, row*H_ACTIVE+col
- vram_din  out  12  write data
- busy  out  1  command in progress
- done  out  1  one-cycle pulse when a command completes

Behaviour:
- Reset (async, rst=1): state=IDLE, cmd_ready=1, vram_we=0, vram_addr_w=0, vram_din=0, busy=0, done=0. Internal counters are cleared.
- Reset mid-fill: the command is dropped immediately; no further writes are issued.
- States: IDLE, CLIP, FILL, DONE.
- IDLE:
  - cmd_ready=1, busy=0.
  - On cmd_valid&cmd_ready, latch all cmd_* fields, then go to CLIP. cmd_ready drops the next cycle.
  - At most one command is held; no queue.
- CLIP (1 cycle):
  - xe=min(x1,H_ACTIVE-1), ye=min(y1,V_ACTIVE-1).
  - The command is empty if x0>xe, y0>ye, x0>=H_ACTIVE, or y0>=V_ACTIVE.
  - Empty: go to DONE with zero writes.
  - Otherwise: col=x0, row=y0, row_base=y0*H_ACTIVE (shift-add: y0<<9 + y0<<7), then go to FILL.
- FILL:
  - vram_we=1, vram_addr_w=row_base+col, vram_din=color. All outputs are registered.
  - The first write is visible 2 cycles after the accept edge.
  - wr_stall=1: hold vram_we, vram_addr_w, and vram_din unchanged and do not advance. A write counts only on a cycle with vram_we=1 and wr_stall=0.
  - Advance:
    - If col<xe: col+1.
    - Else if row<ye: col=x0, row+1, row_base+=H_ACTIVE (no multiplier in the loop).
    - Else: go to DONE, with vram_we=0 on the next cycle.
- DONE (1 cycle): done=1, busy=0 afterwards, then return to IDLE with cmd_ready=1.
- Minimum command-to-command spacing is 3 cycles, plus pixel count and stall cycles.
- busy=1 in CLIP, FILL, and DONE.
- cmd_ready=1 only in IDLE.
- Arithmetic: addresses are unsigned 19-bit. The maximum address 479*640+639=307199 fits without wrap.
- Writes are row-major, left to right then top to bottom. Exactly (xe-x0+1)*(ye-y0+1) writes occur per non-empty command.
- cmd_valid asserted while busy is ignored; the cmd_* fields are not sampled.

Decomposition:
- Shared package vga_pkg:
  - H_ACTIVE, V_ACTIVE, AW, DW.
  - The RGB444 pixel typedef and field-slicing helpers.
  - The state enum rect_state_t (IDLE/CLIP/FILL/DONE).
  - These constants are shared with the VGA controller and the frame dump.
- Sub-module rect_clip:
  - Combinational clamp plus empty detect.
  - Registered in CLIP.
  - Natural unit for standalone testing.
- The address/counter datapath stays in the top module.

Test Plan:
- Single pixel: x0=x1=5, y0=y1=3, color=0xF00. Exactly one write, addr=1925, din=0xF00, at accept+2. done pulses 1 cycle after the write.
- 3x2 rect: x0=638,x1=640 (clipped to 639), y0=0,y1=1. Writes addr 638,639,1278,1279 in order, 4 writes total.
- Full-screen corner: x0=639,y0=479,x1=1023,y1=511. Single write at addr 307199, no wrap.
- Empty: x0=10,x1=4 (also x0=700). Zero writes, vram_we never 1, done at accept+2, cmd_ready back at accept+3.
- Stall: 4x1 rect with wr_stall=1 for 3 cycles during the 2nd write. Address/data held for 3 cycles, still 4 unique writes, done delayed by 3 cycles.
- Reset mid-fill: 100x100 rect, rst asserted after 50 writes. vram_we=0 immediately, cmd_ready=1 after release, and a new command executes correctly.
